// File: rtl/instruction_fetch.sv
// Purpose: MIPS IF stage; owns the PC, addresses the instruction RAM, fills the IF/ID register.
// Latency: a PC set at edge N is read by the RAM on the falling edge and captured in IF/ID at edge N+1.
// Backpressure: i_stall holds the PC and IF/ID; i_enable=0 freezes everything; HALT stops fetch until reset.
module instruction_fetch #(
    parameter int          PC_W      = 32,
    parameter int          ADDR_W    = 11,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter int          CNT_W     = 32
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              i_enable,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_target,
    input  logic [31:0]       i_instr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_instr,
    output logic [PC_W-1:0]   o_pc_plus4,
    output logic              o_valid,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_fetch_count
);

    // Word-alignment mask for redirect targets: the low two byte-address bits are dropped.
    localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

    logic [PC_W-1:0]  pc_q,       pc_d;
    logic [31:0]      instr_q,    instr_d;
    logic [PC_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic             valid_q,    valid_d;
    logic             halted_q,   halted_d;
    logic [CNT_W-1:0] count_q,    count_d;

    logic [PC_W-1:0]  pc_inc;
    logic             is_halt;

    // Sequential PC increment wraps naturally at 2^PC_W.
    assign pc_inc  = pc_q + PC_W'(4);
    assign is_halt = (i_instr == HALT_WORD);

    // RAM word address: byte offset dropped, upper bits alias back into the 2K-word array.
    assign o_addr = pc_q[ADDR_W+1:2];

    // Next-state selection in priority order: freeze, redirect, halted, stall, normal fetch.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        halted_d   = halted_q;
        count_d    = count_q;

        if (!i_enable) begin
            // Debug freeze: every register keeps its value.
        end else if (i_redirect) begin
            // Inject a bubble; the word in flight (even a HALT) belongs to the wrong path.
            // A HALT latched earlier stays sticky, so halted_d is left untouched.
            pc_d    = i_target & ALIGN_MASK;
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (halted_q) begin
            // Halted: keep feeding bubbles, PC parked on the HALT word.
            instr_d = 32'h0;
            valid_d = 1'b0;
        end else if (i_stall) begin
            // Hazard stall: PC and IF/ID hold.
        end else begin
            instr_d    = i_instr;
            pc_plus4_d = pc_inc;
            valid_d    = 1'b1;
            count_d    = count_q + CNT_W'(1);
            if (is_halt) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // State registers with synchronous active-low reset that overrides every other input.
    always_ff @(posedge clka) begin
        if (!rsta) begin
            pc_q       <= '0;
            instr_q    <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
            count_q    <= count_d;
        end
    end

    assign o_instr       = instr_q;
    assign o_pc_plus4    = pc_plus4_q;
    assign o_valid       = valid_q;
    assign o_halted      = halted_q;
    assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Purpose: bench for instruction_fetch with a falling-edge RAM model and an expected-state scoreboard.
// Latency: each table step drives inputs, then checks the IF/ID state one rising edge later.
// Backpressure: stall, enable and redirect are driven directly from per-test stimulus tables.
module tb_instruction_fetch;

    localparam logic [31:0] W0 = 32'h2001_0001;
    localparam logic [31:0] W1 = 32'h2002_0002;
    localparam logic [31:0] W2 = 32'h0022_1820;
    localparam logic [31:0] W3 = 32'hFFFF_FFFF;
    localparam logic [31:0] WTOP = 32'h0BAD_07FF;

    logic        clka = 1'b0;
    logic        rsta = 1'b0;
    logic        i_enable = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_target = 32'h0;
    logic [31:0] i_instr = 32'h0;
    logic [10:0] o_addr;
    logic [31:0] o_instr;
    logic [31:0] o_pc_plus4;
    logic        o_valid;
    logic        o_halted;
    logic [31:0] o_fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        halted;
        logic [10:0] addr;
        logic [31:0] cnt;
    } obs_t;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
    } stim_t;

    obs_t exp_q[$];

    instruction_fetch dut (
        .clka          (clka),
        .rsta          (rsta),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_target      (i_target),
        .i_instr       (i_instr),
        .o_addr        (o_addr),
        .o_instr       (o_instr),
        .o_pc_plus4    (o_pc_plus4),
        .o_valid       (o_valid),
        .o_halted      (o_halted),
        .o_fetch_count (o_fetch_count)
    );

    always #5 clka = ~clka;

    // Instruction RAM: LOW_LATENCY instance samples the address on the falling edge.
    logic [31:0] mem [0:2047];
    always @(negedge clka) i_instr <= mem[o_addr];

    function automatic logic [31:0] word_at(input int i);
        logic [31:0] w;
        w = 32'hA000_0000 | 32'(i);
        return w;
    endfunction

    function automatic obs_t mk(input logic [31:0] instr, input logic [31:0] pc4, input logic v,
                                input logic h, input logic [10:0] addr, input logic [31:0] cnt);
        obs_t e;
        e = '{instr: instr, pc4: pc4, valid: v, halted: h, addr: addr, cnt: cnt};
        return e;
    endfunction

    function automatic stim_t S(input logic rst_n, input logic en, input logic stall,
                                input logic redir, input logic [31:0] tgt);
        stim_t s;
        s = '{rst_n: rst_n, en: en, stall: stall, redir: redir, tgt: tgt};
        return s;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o = '{instr: o_instr, pc4: o_pc_plus4, valid: o_valid, halted: o_halted,
              addr: o_addr, cnt: o_fetch_count};
        return o;
    endfunction

    task automatic drive(input stim_t s);
        rsta       = s.rst_n;
        i_enable   = s.en;
        i_stall    = s.stall;
        i_redirect = s.redir;
        i_target   = s.tgt;
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 1, 1, 32'h40)); ex.push_back(mk(0, 0, 0, 0, 0, 0));
        st.push_back(S(0, 0, 0, 1, 32'h80)); ex.push_back(mk(0, 0, 0, 0, 0, 0));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    task automatic test_free_run();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 0, 0, 0)); ex.push_back(mk(0,  0,  0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(W0, 4,  1, 0, 1, 1));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(W1, 8,  1, 0, 2, 2));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(W2, 12, 1, 0, 3, 3));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(W3, 16, 1, 1, 3, 4));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(0,  16, 0, 1, 3, 4));
        st.push_back(S(1, 1, 0, 0, 0)); ex.push_back(mk(0,  16, 0, 1, 3, 4));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL free_run step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    // Stall at pc=8, then redirect (with stall high) while the HALT word at pc=12 is in flight.
    task automatic test_stall_redirect();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 0, 0, 0));     ex.push_back(mk(0,  0,  0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0));     ex.push_back(mk(W0, 4,  1, 0, 1, 1));
        st.push_back(S(1, 1, 0, 0, 0));     ex.push_back(mk(W1, 8,  1, 0, 2, 2));
        st.push_back(S(1, 1, 1, 0, 0));     ex.push_back(mk(W1, 8,  1, 0, 2, 2));
        st.push_back(S(1, 1, 1, 0, 0));     ex.push_back(mk(W1, 8,  1, 0, 2, 2));
        st.push_back(S(1, 1, 0, 0, 0));     ex.push_back(mk(W2, 12, 1, 0, 3, 3));
        st.push_back(S(1, 1, 1, 1, 32'h43)); ex.push_back(mk(0, 12, 0, 0, 11'h10, 3));
        st.push_back(S(1, 1, 0, 0, 0));     ex.push_back(mk(word_at(16), 32'h44, 1, 0, 11'h11, 4));
        st.push_back(S(1, 1, 0, 0, 0));     ex.push_back(mk(word_at(17), 32'h48, 1, 0, 11'h12, 5));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL stall_redirect step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    // Enable low for 5 cycles (with stall/redirect noise), then a single-cycle step.
    task automatic test_enable_step();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 0, 0, 0));      ex.push_back(mk(0,  0, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 0, 0, 0, 0));      ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 0, 1, 0, 0));      ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 0, 0, 1, 32'h100)); ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 0, 1, 1, 32'h200)); ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 0, 0, 0, 0));      ex.push_back(mk(W0, 4, 1, 0, 1, 1));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W1, 8, 1, 0, 2, 2));
        st.push_back(S(1, 0, 0, 0, 0));      ex.push_back(mk(W1, 8, 1, 0, 2, 2));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL enable_step step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    // Halt, redirect while halted (pc moves, fetch does not resume), then reset restarts.
    task automatic test_halt_redirect_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 0, 0, 0));      ex.push_back(mk(0,  0,  0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W0, 4,  1, 0, 1, 1));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W1, 8,  1, 0, 2, 2));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W2, 12, 1, 0, 3, 3));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W3, 16, 1, 1, 3, 4));
        st.push_back(S(1, 1, 0, 1, 32'h20)); ex.push_back(mk(0,  16, 0, 1, 8, 4));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(0,  16, 0, 1, 8, 4));
        st.push_back(S(1, 1, 1, 0, 0));      ex.push_back(mk(0,  16, 0, 1, 8, 4));
        st.push_back(S(1, 1, 0, 1, 32'h0E)); ex.push_back(mk(0,  16, 0, 1, 3, 4));
        st.push_back(S(0, 1, 1, 1, 32'h40)); ex.push_back(mk(0,  0,  0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0));      ex.push_back(mk(W0, 4,  1, 0, 1, 1));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL halt_reset step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    // PC wrap from 0xFFFFFFFC to 0 and aliasing of 0x2004 onto word 1.
    task automatic test_wrap_alias();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  e, o;
        st.push_back(S(0, 1, 0, 0, 0));             ex.push_back(mk(0,    0, 0, 0, 0, 0));
        st.push_back(S(1, 1, 0, 0, 0));             ex.push_back(mk(W0,   4, 1, 0, 1, 1));
        st.push_back(S(1, 1, 0, 1, 32'hFFFF_FFFE)); ex.push_back(mk(0,    4, 0, 0, 11'h7FF, 1));
        st.push_back(S(1, 1, 0, 0, 0));             ex.push_back(mk(WTOP, 0, 1, 0, 0, 2));
        st.push_back(S(1, 1, 0, 0, 0));             ex.push_back(mk(W0,   4, 1, 0, 1, 3));
        st.push_back(S(1, 1, 0, 1, 32'h2004));      ex.push_back(mk(0,    4, 0, 0, 1, 3));
        st.push_back(S(1, 1, 0, 0, 0));             ex.push_back(mk(W1, 32'h2008, 1, 0, 2, 4));
        foreach (st[i]) begin
            drive(st[i]);
            exp_q.push_back(ex[i]);
            tick();
            e = exp_q.pop_front();
            o = snap();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL wrap_alias step %0d: got instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d want instr=%h pc4=%h v=%b h=%b addr=%h cnt=%0d",
                         i, o.instr, o.pc4, o.valid, o.halted, o.addr, o.cnt,
                         e.instr, e.pc4, e.valid, e.halted, e.addr, e.cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = word_at(i);
        mem[0]     = W0;
        mem[1]     = W1;
        mem[2]     = W2;
        mem[3]     = W3;
        mem[2047]  = WTOP;

        test_reset();
        test_free_run();
        test_stall_redirect();
        test_enable_step();
        test_halt_redirect_reset();
        test_wrap_alias();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
MIPS pipeline IF stage that sits directly upstream of the instruction RAM. It owns the program counter and drives the RAM word address. It captures the returned instruction into the IF/ID pipeline register, and handles stall, branch/jump redirect, debug single-step enable and HALT detection. The RAM is the 2048x32 instance configured LOW_LATENCY: it samples the address on the falling edge, so the instruction for the current PC is valid before the next rising edge.

Parameters:
PC_W, 32, program counter width in bits (byte address)
ADDR_W, 11, instruction RAM word-address width (clog2 of 2048)
HALT_WORD, 32'hFFFFFFFF, encoding that stops fetch
CNT_W, 32, width of the fetched-instruction counter

Ports:
clka  in  1  clock; rising edge for this block, RAM uses falling edge
rsta  in  1  synchronous, active-low reset
i_enable  in  1  debug-unit enable; 0 freezes all state (step mode pulses it for 1 cycle)
i_stall  in  1  hazard-unit stall; holds PC and IF/ID
i_redirect  in  1  taken branch/jump resolved downstream
i_target  in  PC_W  redirect byte address
i_instr  in  32  instruction word from RAM (douta)
o_addr  out  ADDR_W  RAM word address = pc[ADDR_W+1:2], combinational from PC
o_instr  out  32  IF/ID instruction
o_pc_plus4  out  PC_W  IF/ID PC+4 of o_instr
o_valid  out  1  IF/ID holds a real instruction
o_halted  out  1  sticky HALT-fetched flag
o_fetch_count  out  CNT_W  number of instructions latched with valid=1

Behaviour:
- All state is updated on the rising edge of clka.
- Reset (rsta=0, sampled on the rising edge): pc=0, o_instr=0, o_pc_plus4=0, o_valid=0, o_halted=0, o_fetch_count=0. Reset overrides all other inputs, including mid-stall, mid-redirect and halted.
- Latency: a PC value set at edge N is driven on o_addr during cycle N. The RAM reads it at the falling edge. IF/ID captures it at edge N+1. The first instruction (address 0) appears on o_instr one edge after reset is released.
- Per-edge priority (when not in reset):
  1. i_enable=0: hold everything.
  2. i_redirect=1: pc<=i_target with bits [1:0] forced to 0; o_instr<=0 (NOP); o_valid<=0. The current i_instr is discarded even if it equals HALT_WORD. The redirect clears o_halted only if HALT was not yet latched in an earlier cycle; o_halted stays sticky once set.
  3. o_halted=1: hold pc; o_instr<=0; o_valid<=0.
  4. i_stall=1: hold pc, o_instr, o_pc_plus4 and o_valid.
  5. Normal: o_instr<=i_instr, o_pc_plus4<=pc+4, o_valid<=1, o_fetch_count+=1. Then, if i_instr==HALT_WORD: o_halted<=1 and pc is held. Otherwise pc<=pc+4.
- Stall and redirect in the same cycle: redirect wins.
- Arithmetic: pc+4 is modulo 2^PC_W, so 32'hFFFFFFFC wraps to 0.
- o_addr drops pc[1:0] and all bits above ADDR_W+1. A PC of 0x2000 therefore aliases to word 0. This aliasing is expected; no error is flagged.
- o_fetch_count wraps at 2^CNT_W and counts only normal-path latches.
- Once halted, only reset restarts fetch. i_redirect still updates pc while halted (so debug can observe it), but fetch does not resume.

Test Plan:
- Reset then free run over RAM words 0..3 = 0x20010001, 0x20020002, 0x00221820, 0xFFFFFFFF:
  - o_instr follows these words on consecutive edges, with o_pc_plus4 = 4, 8, 12, 16.
  - o_halted=1 after the 4th edge; o_fetch_count=4.
  - pc is held at 12 and o_valid drops to 0 on the next edge.
- Stall for 2 cycles at pc=8: o_addr stays 2 and o_instr/o_pc_plus4 are unchanged for both cycles. On the next edge o_instr=word2 and o_pc_plus4=12.
- i_redirect with i_target=0x00000043 while i_stall=1: pc=0x40, o_valid=0, o_instr=0. On the following edge o_instr=word16 and o_pc_plus4=0x44.
- Redirect in the same cycle that i_instr==HALT_WORD: o_halted stays 0 and fetch continues from the target.
- i_enable held at 0 for 5 cycles, then pulsed for 1 cycle: state is frozen during the 5 cycles, then exactly one instruction advances and o_fetch_count increments by 1.
- Reset asserted while halted at pc=12: on the next edge pc=0, o_halted=0, o_valid=0 and o_fetch_count=0; word0 is re-fetched after reset is released.
